// File: rtl/dual_issue_ctrl.sv
// dual_issue_ctrl: two-wide in-order issue controller for an RV32I front end.
// Each cycle it issues the fetched (A, B) pair together when B has no dependence
// on A. Otherwise it issues A alone, parks B in a hold register and stalls fetch.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   InstrA_i / InstrB_i        older / younger fetched instruction
//   PairValid_i, Ready_i       fetch pair valid, both decode lanes ready
//   Flush_i                    redirect; drops the held and in-flight issue state
//   FetchStall_o               combinational fetch hold (1 = keep PC)
//   Lane0/1Instr_o, Valid_o    registered issue slots (lane 0 always the older one)
//   PairCount_o, SplitCount_o  dual-issue and split-issue event counters (wrap)
module dual_issue_ctrl #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] InstrA_i,
  input  logic [DATA_WIDTH-1:0] InstrB_i,
  input  logic                  PairValid_i,
  input  logic                  Ready_i,
  input  logic                  Flush_i,
  output logic                  FetchStall_o,
  output logic [DATA_WIDTH-1:0] Lane0Instr_o,
  output logic [DATA_WIDTH-1:0] Lane1Instr_o,
  output logic                  Lane0Valid_o,
  output logic                  Lane1Valid_o,
  output logic [DATA_WIDTH-1:0] PairCount_o,
  output logic [DATA_WIDTH-1:0] SplitCount_o
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic {ST_PAIR = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] hold_b_q;
  logic [DATA_WIDTH-1:0] lane0_instr_q;
  logic [DATA_WIDTH-1:0] lane1_instr_q;
  logic                  lane0_valid_q;
  logic                  lane1_valid_q;
  logic [DATA_WIDTH-1:0] pair_count_q;
  logic [DATA_WIDTH-1:0] split_count_q;

  // Instruction fields used by the hazard check
  logic [6:0] a_op, b_op;
  logic [4:0] a_rd, b_rs1, b_rs2;

  assign a_op  = InstrA_i[6:0];
  assign a_rd  = InstrA_i[11:7];
  assign b_op  = InstrB_i[6:0];
  assign b_rs1 = InstrB_i[19:15];
  assign b_rs2 = InstrB_i[24:20];

  logic a_writes_rd, a_is_mem, a_is_ctl;
  logic b_reads_rs1, b_reads_rs2, b_is_mem;
  logic conflict_c;

  // Per-instruction decode and pair hazard detection
  always_comb begin
    a_writes_rd = 1'b0;
    a_is_mem    = 1'b0;
    a_is_ctl    = 1'b0;
    b_reads_rs1 = 1'b0;
    b_reads_rs2 = 1'b0;
    b_is_mem    = 1'b0;

    case (a_op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
      OP_LOAD, OP_OPIMM, OP_OP:         a_writes_rd = (a_rd != 5'd0);
      default:                          a_writes_rd = 1'b0;
    endcase
    a_is_mem = (a_op == OP_LOAD) || (a_op == OP_STORE);
    a_is_ctl = (a_op == OP_JAL) || (a_op == OP_JALR) || (a_op == OP_BRANCH);

    case (b_op)
      OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_OPIMM, OP_OP: b_reads_rs1 = 1'b1;
      default:                                                b_reads_rs1 = 1'b0;
    endcase
    case (b_op)
      OP_BRANCH, OP_STORE, OP_OP: b_reads_rs2 = 1'b1;
      default:                    b_reads_rs2 = 1'b0;
    endcase
    b_is_mem = (b_op == OP_LOAD) || (b_op == OP_STORE);

    conflict_c = (a_writes_rd && ((b_reads_rs1 && (b_rs1 == a_rd)) ||
                                  (b_reads_rs2 && (b_rs2 == a_rd)))) ||
                 (a_is_mem && b_is_mem) ||
                 a_is_ctl;
  end

  // Fetch hold: flush and reset release fetch; otherwise stall on a backpressured
  // lane or on the cycle a conflicting pair is being split.
  always_comb begin
    FetchStall_o = 1'b0;
    if (rst || Flush_i) begin
      FetchStall_o = 1'b0;
    end else if (!Ready_i) begin
      FetchStall_o = 1'b1;
    end else if ((state_q == ST_PAIR) && PairValid_i && conflict_c) begin
      FetchStall_o = 1'b1;
    end
  end

  // Issue FSM, hold register, lanes and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_PAIR;
      hold_b_q      <= '0;
      lane0_instr_q <= '0;
      lane1_instr_q <= '0;
      lane0_valid_q <= 1'b0;
      lane1_valid_q <= 1'b0;
      pair_count_q  <= '0;
      split_count_q <= '0;
    end else if (Flush_i) begin
      state_q       <= ST_PAIR;
      hold_b_q      <= '0;
      lane0_instr_q <= '0;
      lane1_instr_q <= '0;
      lane0_valid_q <= 1'b0;
      lane1_valid_q <= 1'b0;
    end else if (Ready_i) begin
      case (state_q)
        ST_PAIR: begin
          if (PairValid_i) begin
            lane0_instr_q <= InstrA_i;
            lane0_valid_q <= 1'b1;
            if (conflict_c) begin
              lane1_instr_q <= '0;
              lane1_valid_q <= 1'b0;
              hold_b_q      <= InstrB_i;
              split_count_q <= split_count_q + DATA_WIDTH'(1);
              state_q       <= ST_HOLD;
            end else begin
              lane1_instr_q <= InstrB_i;
              lane1_valid_q <= 1'b1;
              pair_count_q  <= pair_count_q + DATA_WIDTH'(1);
            end
          end else begin
            lane0_instr_q <= '0;
            lane1_instr_q <= '0;
            lane0_valid_q <= 1'b0;
            lane1_valid_q <= 1'b0;
          end
        end
        ST_HOLD: begin
          // Younger instruction of a split pair issues alone in lane 0
          lane0_instr_q <= hold_b_q;
          lane0_valid_q <= 1'b1;
          lane1_instr_q <= '0;
          lane1_valid_q <= 1'b0;
          hold_b_q      <= '0;
          state_q       <= ST_PAIR;
        end
        default: state_q <= ST_PAIR;
      endcase
    end
  end

  assign Lane0Instr_o = lane0_instr_q;
  assign Lane1Instr_o = lane1_instr_q;
  assign Lane0Valid_o = lane0_valid_q;
  assign Lane1Valid_o = lane1_valid_q;
  assign PairCount_o  = pair_count_q;
  assign SplitCount_o = split_count_q;

endmodule
